// File: rtl/flash_write_scheduler.sv
// Splits one host write job into sector-erase / page-program commands for the SPI flash engine.
// Optional FLASH_SCHED_BOUNDS_EN: reject zero-length or out-of-flash jobs with a req_err pulse.
module flash_write_scheduler #(
  parameter int ADDR_W   = 32,
  parameter int LEN_W    = 16,
  parameter int GAP_CYC  = 3,
  parameter int FLASH_LG = 24
) (
  input  logic              system_clk,
  input  logic              system_reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_num,
  input  logic              req_mode,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_op,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [8:0]        cmd_len,
  output logic              cmd_quad,
  input  logic              cmd_done,
  output logic              se_done,
  output logic              pp_done,
  output logic              write_finish,
  output logic              busy,
  output logic              req_err
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SE_ISSUE = 3'd1;
  localparam logic [2:0] S_SE_WAIT  = 3'd2;
  localparam logic [2:0] S_PP_ISSUE = 3'd3;
  localparam logic [2:0] S_PP_WAIT  = 3'd4;
  localparam logic [2:0] S_GAP      = 3'd5;
  localparam logic [2:0] S_FINISH   = 3'd6;

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  logic [2:0]        state_q, state_d;
  logic [2:0]        next_q, next_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  remain_q, remain_d;
  logic              mode_q, mode_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              se_done_q, se_done_d;
  logic              pp_done_q, pp_done_d;
  logic              finish_q, finish_d;

  // Page length: stop at the next 256 B boundary or at the end of the job.
  logic [8:0] page_room;
  logic [8:0] pp_len;
  assign page_room = 9'd256 - {1'b0, addr_q[7:0]};
  assign pp_len    = (remain_q < LEN_W'(page_room)) ? remain_q[8:0] : page_room;

`ifdef FLASH_SCHED_BOUNDS_EN
  localparam logic [ADDR_W:0] FLASH_BYTES = (ADDR_W+1)'(1) << FLASH_LG;
  logic [ADDR_W:0] req_end;
  logic            req_bad;
  logic            req_err_q, req_err_d;
  assign req_end = {1'b0, req_addr} + (ADDR_W+1)'(req_num);
  assign req_bad = (req_num == '0) || (req_end > FLASH_BYTES);
  assign req_err = req_err_q;
`else
  assign req_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    next_d    = next_q;
    addr_d    = addr_q;
    remain_d  = remain_q;
    mode_d    = mode_q;
    gap_d     = gap_q;
    se_done_d = 1'b0;
    pp_done_d = 1'b0;
    finish_d  = 1'b0;
`ifdef FLASH_SCHED_BOUNDS_EN
    req_err_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          remain_d = req_num;
          mode_d   = req_mode;
`ifdef FLASH_SCHED_BOUNDS_EN
          if (req_bad) req_err_d = 1'b1;
          else         state_d   = S_SE_ISSUE;
`else
          state_d = (req_num == '0) ? S_FINISH : S_SE_ISSUE;
`endif
        end
      end
      S_SE_ISSUE: if (cmd_ready) state_d = S_SE_WAIT;
      S_SE_WAIT: begin
        if (cmd_done) begin
          se_done_d = 1'b1;
          gap_d     = '0;
          next_d    = S_PP_ISSUE;
          state_d   = S_GAP;
        end
      end
      S_PP_ISSUE: if (cmd_ready) state_d = S_PP_WAIT;
      S_PP_WAIT: begin
        if (cmd_done) begin
          pp_done_d = 1'b1;
          addr_d    = addr_q + ADDR_W'(pp_len);
          remain_d  = remain_q - LEN_W'(pp_len);
          gap_d     = '0;
          if (remain_d == '0) begin
            state_d = S_FINISH;
          end else begin
            state_d = S_GAP;
            next_d  = (addr_d[11:0] == 12'h000) ? S_SE_ISSUE : S_PP_ISSUE;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_W'(GAP_CYC - 1)) state_d = next_q;
        else                              gap_d   = gap_q + 1'b1;
      end
      // Two cycles: the first lines up with the final pp_done, the second carries write_finish.
      S_FINISH: begin
        if (!finish_q) finish_d = 1'b1;
        else           state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge system_clk or posedge system_reset) begin
    if (system_reset) begin
      state_q   <= S_IDLE;
      next_q    <= S_IDLE;
      addr_q    <= '0;
      remain_q  <= '0;
      mode_q    <= 1'b0;
      gap_q     <= '0;
      se_done_q <= 1'b0;
      pp_done_q <= 1'b0;
      finish_q  <= 1'b0;
`ifdef FLASH_SCHED_BOUNDS_EN
      req_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      next_q    <= next_d;
      addr_q    <= addr_d;
      remain_q  <= remain_d;
      mode_q    <= mode_d;
      gap_q     <= gap_d;
      se_done_q <= se_done_d;
      pp_done_q <= pp_done_d;
      finish_q  <= finish_d;
`ifdef FLASH_SCHED_BOUNDS_EN
      req_err_q <= req_err_d;
`endif
    end
  end

  // Command fields depend only on registers, so they cannot move while the engine stalls.
  assign req_ready    = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign cmd_valid    = (state_q == S_SE_ISSUE) || (state_q == S_PP_ISSUE);
  assign cmd_op       = (state_q == S_PP_ISSUE);
  assign cmd_addr     = (state_q == S_SE_ISSUE) ? {addr_q[ADDR_W-1:12], 12'h000} :
                        (state_q == S_PP_ISSUE) ? addr_q : '0;
  assign cmd_len      = (state_q == S_PP_ISSUE) ? pp_len : 9'd0;
  assign cmd_quad     = (state_q == S_PP_ISSUE) && mode_q;
  assign se_done      = se_done_q;
  assign pp_done      = pp_done_q;
  assign write_finish = finish_q;

endmodule

// File: tb/tb_flash_write_scheduler.sv
// Directed bench for flash_write_scheduler: engine model driven from tasks, hand-computed command lists.
module tb_flash_write_scheduler;

  localparam int ADDR_W  = 32;
  localparam int LEN_W   = 16;
  localparam int GAP_CYC = 3;

  logic              system_clk = 1'b0;
  logic              system_reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [LEN_W-1:0]  req_num = '0;
  logic              req_mode = 1'b0;
  logic              cmd_valid;
  logic              cmd_ready = 1'b0;
  logic              cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [8:0]        cmd_len;
  logic              cmd_quad;
  logic              cmd_done = 1'b0;
  logic              se_done, pp_done, write_finish, busy, req_err;

  flash_write_scheduler #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .GAP_CYC(GAP_CYC), .FLASH_LG(24)
  ) dut (
    .system_clk(system_clk), .system_reset(system_reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_num(req_num), .req_mode(req_mode),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_quad(cmd_quad),
    .cmd_done(cmd_done), .se_done(se_done), .pp_done(pp_done),
    .write_finish(write_finish), .busy(busy), .req_err(req_err)
  );

  always #5 system_clk = ~system_clk;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int se_cnt = 0, pp_cnt = 0, fin_cnt = 0, err_cnt = 0;
  int s0, p0, f0, e0;

  always @(negedge system_clk) begin
    if (se_done)      se_cnt  <= se_cnt + 1;
    if (pp_done)      pp_cnt  <= pp_cnt + 1;
    if (write_finish) fin_cnt <= fin_cnt + 1;
    if (req_err)      err_cnt <= err_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic snap();
    s0 = se_cnt; p0 = pp_cnt; f0 = fin_cnt; e0 = err_cnt;
  endtask

  task automatic start_job(input logic [31:0] a, input int n, input logic m);
    int t;
    t = 0;
    while (!req_ready && t < 100) begin @(negedge system_clk); t++; end
    check("req_ready_wait", req_ready, 1);
    req_valid = 1'b1;
    req_addr  = a;
    req_num   = n[15:0];
    req_mode  = m;
    @(negedge system_clk);
    req_valid = 1'b0;
    $display("job addr=0x%06h num=%0d mode=%0d", a, n, m);
  endtask

  // Serve one command: match fields, accept, complete, then check the gap or the finish sequence.
  task automatic do_cmd(input logic eop, input logic [31:0] eaddr, input int elen, input logic equad,
                        input int hold, input bit last, input bit ready_with_done);
    int t;
    t = 0;
    while (!cmd_valid && t < 100) begin @(negedge system_clk); t++; end
    check("cmd_valid_wait", cmd_valid, 1);
    repeat (hold) @(negedge system_clk);
    if (hold > 0) check("cmd_valid_held", cmd_valid, 1);
    check("cmd_op", cmd_op, eop);
    check("cmd_addr", cmd_addr, eaddr);
    check("cmd_len", cmd_len, elen);
    check("cmd_quad", cmd_quad, equad);
    $display("cmd op=%0d addr=0x%06h len=%0d quad=%0d", cmd_op, cmd_addr, cmd_len, cmd_quad);
    cmd_ready = 1'b1;
    cmd_done  = ready_with_done;
    @(negedge system_clk);
    cmd_ready = 1'b0;
    cmd_done  = 1'b0;
    check("cmd_valid_drop", cmd_valid, 0);
    if (ready_with_done) check("early_done_ignored", {se_done, pp_done}, 0);
    repeat (2) @(negedge system_clk);
    cmd_done = 1'b1;
    @(negedge system_clk);
    cmd_done = 1'b0;
    if (eop) check("pp_done_pulse", pp_done, 1);
    else     check("se_done_pulse", se_done, 1);
    if (!last) begin
      t = 1;
      while (!cmd_valid && t < 100) begin @(negedge system_clk); t++; end
      check("gap_cycles", t, GAP_CYC + 1);
    end else begin
      check("finish_not_early", write_finish, 0);
      @(negedge system_clk);
      check("write_finish", write_finish, 1);
      check("ready_low_in_finish", req_ready, 0);
      @(negedge system_clk);
      check("req_ready_back", req_ready, 1);
      check("finish_one_cycle", write_finish, 0);
    end
  endtask

  task automatic check_job_counts(input int se, input int pp, input int fin);
    check("se_count", se_cnt - s0, se);
    check("pp_count", pp_cnt - p0, pp);
    check("finish_count", fin_cnt - f0, fin);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge system_clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_cmd_fields", {cmd_op, cmd_addr, cmd_len, cmd_quad}, 0);
    check("rst_pulses", {se_done, pp_done, write_finish, req_err}, 0);
    system_reset = 1'b0;
    repeat (2) @(negedge system_clk);

    // 512 B from 0: one SE, two full pages.
    snap();
    start_job(32'h0000, 512, 1'b0);
    check("cmd_valid_after_accept", cmd_valid, 1);
    check("busy_after_accept", busy, 1);
    do_cmd(1'b0, 32'h0000, 0, 1'b0, 0, 0, 0);
    do_cmd(1'b1, 32'h0000, 256, 1'b0, 0, 0, 0);
    do_cmd(1'b1, 32'h0100, 256, 1'b0, 0, 1, 0);
    check_job_counts(1, 2, 1);

    // 5120 B from 0x1000 crosses into a second sector; first SE stalled by the engine.
    snap();
    start_job(32'h1000, 5120, 1'b0);
    do_cmd(1'b0, 32'h1000, 0, 1'b0, 10, 0, 0);
    for (int i = 0; i < 16; i++) do_cmd(1'b1, 32'h1000 + i * 256, 256, 1'b0, 0, 0, 0);
    do_cmd(1'b0, 32'h2000, 0, 1'b0, 0, 0, 1);
    for (int i = 0; i < 4; i++) do_cmd(1'b1, 32'h2000 + i * 256, 256, 1'b0, 0, i == 3, 0);
    check_job_counts(2, 20, 1);

    // Quad job: SE never quad, every PP quad.
    snap();
    start_job(32'h2000, 2048, 1'b1);
    do_cmd(1'b0, 32'h2000, 0, 1'b0, 0, 0, 0);
    for (int i = 0; i < 8; i++) do_cmd(1'b1, 32'h2000 + i * 256, 256, 1'b1, 0, i == 7, 0);
    check_job_counts(1, 8, 1);

    // Unaligned start straddling a sector boundary.
    snap();
    start_job(32'h0FF0, 32, 1'b0);
    do_cmd(1'b0, 32'h0000, 0, 1'b0, 0, 0, 0);
    do_cmd(1'b1, 32'h0FF0, 16, 1'b0, 0, 0, 0);
    do_cmd(1'b0, 32'h1000, 0, 1'b0, 0, 0, 0);
    do_cmd(1'b1, 32'h1000, 16, 1'b0, 0, 1, 0);
    check_job_counts(2, 2, 1);

    // Reset while a PP is outstanding.
    start_job(32'h3000, 300, 1'b0);
    do_cmd(1'b0, 32'h3000, 0, 1'b0, 0, 0, 0);
    check("pp_before_reset_len", cmd_len, 256);
    cmd_ready = 1'b1;
    @(negedge system_clk);
    cmd_ready = 1'b0;
    snap();
    system_reset = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_req_ready", req_ready, 1);
    check("midrst_cmd_valid", cmd_valid, 0);
    @(negedge system_clk);
    system_reset = 1'b0;
    repeat (6) @(negedge system_clk);
    check("midrst_no_finish", fin_cnt - f0, 0);
    check("midrst_idle_cmd", cmd_valid, 0);

    // Job after reset runs normally: partial page inside one sector.
    snap();
    start_job(32'h5080, 128, 1'b1);
    do_cmd(1'b0, 32'h5000, 0, 1'b0, 0, 0, 0);
    do_cmd(1'b1, 32'h5080, 128, 1'b1, 0, 1, 0);
    check_job_counts(1, 1, 1);

`ifdef FLASH_SCHED_BOUNDS_EN
    snap();
    start_job(32'hFFFF00, 512, 1'b0);
    check("oob_req_err", req_err, 1);
    check("oob_idle", req_ready, 1);
    check("oob_no_cmd", cmd_valid, 0);
    @(negedge system_clk);
    check("oob_err_one_cycle", req_err, 0);
    repeat (6) @(negedge system_clk);
    check("oob_no_cmd_later", cmd_valid, 0);
    check_job_counts(0, 0, 0);
    check("oob_err_count", err_cnt - e0, 1);

    snap();
    start_job(32'h0100, 0, 1'b0);
    check("zero_req_err", req_err, 1);
    repeat (6) @(negedge system_clk);
    check_job_counts(0, 0, 0);

    // Ends exactly at the top of the 16 MB device: accepted.
    snap();
    start_job(32'hFFFF00, 256, 1'b0);
    check("top_no_err", req_err, 0);
    do_cmd(1'b0, 32'hFFF000, 0, 1'b0, 0, 0, 0);
    do_cmd(1'b1, 32'hFFFF00, 256, 1'b0, 0, 1, 0);
    check_job_counts(1, 1, 1);
`else
    snap();
    start_job(32'h0100, 0, 1'b0);
    check("zero_no_cmd", cmd_valid, 0);
    check("zero_busy", busy, 1);
    check("zero_finish_not_yet", write_finish, 0);
    @(negedge system_clk);
    check("zero_write_finish", write_finish, 1);
    @(negedge system_clk);
    check("zero_req_ready_back", req_ready, 1);
    check("zero_req_err_tied", req_err, 0);
    repeat (4) @(negedge system_clk);
    check_job_counts(0, 0, 1);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/flash_write_scheduler.md
# flash_write_scheduler

Command scheduler that sits between the host write interface and the SPI flash command engine. It accepts one write job (start address, byte count, single/quad mode), splits it into sector-erase and page-program commands that respect 4 KB sector and 256 B page boundaries, and issues them one at a time over a valid/ready/done handshake. It enforces a minimum idle gap after every command and reports `se_done`, `pp_done` and `write_finish` pulses.

## Interface
- `ADDR_W`, 32, flash byte address width
- `LEN_W`, 16, job byte-count width
- `GAP_CYC`, 3, idle cycles enforced after each `cmd_done` before the next `cmd_valid` (covers tSE/tPP settle; 3 × 20 ns ≥ 60 ns)
- `FLASH_LG`, 24, log2 of flash size in bytes (used only with `FLASH_SCHED_BOUNDS_EN`)
- `system_clk` in 1: single clock, all logic on its rising edge
- `system_reset` in 1: asynchronous, active-high reset
- `req_valid` in 1: job request
- `req_ready` out 1: high only in IDLE
- `req_addr` in ADDR_W: job start byte address
- `req_num` in LEN_W: job byte count
- `req_mode` in 1: 0 = single-line PP, 1 = quad PP (PPX4)
- `cmd_valid` out 1: command offered to engine
- `cmd_ready` in 1: engine accepts command
- `cmd_op` out 1: 0 = sector erase, 1 = page program
- `cmd_addr` out ADDR_W: SE: sector base (low 12 bits zero); PP: first byte address
- `cmd_len` out 9: PP byte count 1..256; 0 for SE
- `cmd_quad` out 1: `req_mode` for PP; always 0 for SE
- `cmd_done` in 1: one-cycle pulse, engine finished current command
- `se_done`, `pp_done`, `write_finish` out 1: one-cycle status pulses
- `busy` out 1: high whenever state ≠ IDLE
- `req_err` out 1: one-cycle pulse (only with `FLASH_SCHED_BOUNDS_EN`, else tied 0)

## Operation
- States: IDLE, SE_ISSUE, SE_WAIT, PP_ISSUE, PP_WAIT, GAP, FINISH.
- IDLE: on `req_valid && req_ready` latch `cur_addr = req_addr`, `remain = req_num` (zero-extended), `mode = req_mode`; go to SE_ISSUE. `req_num == 0` → FINISH directly, no commands.
- SE_ISSUE: `cmd_valid=1`, `cmd_op=0`, `cmd_addr = {cur_addr[ADDR_W-1:12], 12'h000}`; on `cmd_ready` → SE_WAIT.
- SE_WAIT: on `cmd_done` pulse `se_done`, → GAP (next: PP_ISSUE).
- PP_ISSUE: `len = min(remain, 256 − cur_addr[7:0])`; `cmd_op=1`, `cmd_addr=cur_addr`, `cmd_len=len`, `cmd_quad=mode`; on `cmd_ready` → PP_WAIT. Pages never straddle sectors by construction.
- PP_WAIT: on `cmd_done` pulse `pp_done`; `cur_addr += len`, `remain −= len`; `remain == 0` → FINISH, else GAP (next: SE_ISSUE if new `cur_addr[11:0] == 0`, else PP_ISSUE).
- GAP: count `GAP_CYC` cycles with `cmd_valid=0`, then enter the recorded next state.
- FINISH: pulse `write_finish` one cycle, → IDLE.
- Sector erase always erases the whole containing sector, including bytes before `req_addr`; this is intended.
- Address arithmetic wraps modulo 2^ADDR_W; `cmd_len` computed in 9 bits (256 representable).
- `cmd_addr/op/len/quad` held stable while `cmd_valid && !cmd_ready`.
- `cmd_done` outside SE_WAIT/PP_WAIT is ignored; `req_valid` while busy is ignored.

## Timing
- Reset (async assert, sync-released use): state IDLE, `req_ready=1`, all other outputs 0, counters cleared. Reset mid-job aborts immediately, `cmd_valid` drops same instant, no `write_finish`.
- `cmd_valid` first asserts the cycle after request acceptance.
- `cmd_done` → status pulse and GAP entry on the next edge; next `cmd_valid` exactly `GAP_CYC`+1 cycles after `cmd_done` sampled.
- `write_finish` asserts the cycle after the last `pp_done`; `req_ready` returns the following cycle.
- `cmd_ready` and `cmd_done` in the same cycle: only `cmd_ready` acted on.

## Configuration
- `FLASH_SCHED_BOUNDS_EN` defined: at acceptance, if `req_num == 0` or `req_addr + req_num > 2^FLASH_LG`, pulse `req_err` the next cycle, issue no commands, no `write_finish`, stay IDLE.
- Undefined: no check; `req_num == 0` produces only `write_finish`; `req_err` tied 0.

## Test plan
- addr 0x0000, num 512, mode 0 → SE 0x0000; PP 0x0000 len 256; PP 0x0100 len 256; 1 `se_done`, 2 `pp_done`, 1 `write_finish`.
- addr 0x1000, num 5120 → SE 0x1000, 16 PPs 0x1000..0x1F00, SE 0x2000, 4 PPs 0x2000..0x2300; every `cmd_valid` ≥ 4 cycles after prior `cmd_done`.
- addr 0x2000, num 2048, mode 1 → SE 0x2000 with `cmd_quad=0`; 8 PPs with `cmd_quad=1`.
- addr 0x0FF0, num 32 → SE 0x0000, PP 0x0FF0 len 16, SE 0x1000, PP 0x1000 len 16.
- Engine holds `cmd_ready` low 10 cycles → command fields stable; reset asserted during PP_WAIT → outputs at reset values, later job runs normally.
- With `FLASH_SCHED_BOUNDS_EN`, addr 0xFFFF00, num 512 → `req_err` pulse, zero commands; num 0 → `req_err`; without macro, num 0 → `write_finish` only.
